// File: rtl/cpu64_l3_alloc_ctrl.sv
// L3 line-allocation controller: reads a set, picks a way (tag hit, else PLRU victim),
// writes back a dirty victim if needed, then installs the new tag and updates the PLRU.
module cpu64_l3_alloc_ctrl #(
  parameter int TAG_W    = 23,
  parameter int SET_W    = 11,
  parameter int NUM_WAYS = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      alloc_valid_i,
  output logic                      alloc_ready_o,
  input  logic [SET_W-1:0]          alloc_set_i,
  input  logic [TAG_W-1:0]          alloc_tag_i,
  output logic                      tag_rd_en_o,
  output logic [SET_W-1:0]          tag_rd_set_o,
  input  logic [NUM_WAYS-1:0]       tag_valid_i,
  input  logic [NUM_WAYS-1:0]       tag_dirty_i,
  input  logic [NUM_WAYS*TAG_W-1:0] tag_tags_i,
  output logic [SET_W-1:0]          plru_set_o,
  output logic [NUM_WAYS-1:0]       plru_valid_o,
  input  logic [3:0]                plru_victim_i,
  output logic                      plru_access_o,
  output logic [3:0]                plru_way_o,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [SET_W-1:0]          wb_set_o,
  output logic [3:0]                wb_way_o,
  output logic [TAG_W-1:0]          wb_tag_o,
  output logic                      tag_wr_en_o,
  output logic [SET_W-1:0]          tag_wr_set_o,
  output logic [3:0]                tag_wr_way_o,
  output logic [TAG_W-1:0]          tag_wr_tag_o,
  output logic                      done_o,
  output logic [3:0]                done_way_o,
  output logic                      done_evict_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_PICK, S_WB, S_INST
  } state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [NUM_WAYS-1:0] valid_q, valid_d;
  logic [NUM_WAYS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]   tags_q [NUM_WAYS];
  logic [TAG_W-1:0]   tags_d [NUM_WAYS];
  logic [3:0]         way_q, way_d;
  logic               evict_q, evict_d;

  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit_any;
  logic [3:0]          hit_way;

  // Only valid ways can match, so a stale tag in an invalid way is never reused.
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_hit
    assign hit_vec[gi] = valid_q[gi] && (tags_q[gi] == tag_q);
  end

  always_comb begin
    hit_any = |hit_vec;
    hit_way = '0;
    for (int k = NUM_WAYS - 1; k >= 0; k--) begin
      if (hit_vec[k]) hit_way = 4'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tags_d  = tags_q;
    way_d   = way_q;
    evict_d = evict_q;

    alloc_ready_o = 1'b0;
    tag_rd_en_o   = 1'b0;
    tag_rd_set_o  = '0;
    plru_set_o    = '0;
    plru_valid_o  = '0;
    plru_access_o = 1'b0;
    plru_way_o    = '0;
    wb_valid_o    = 1'b0;
    wb_set_o      = '0;
    wb_way_o      = '0;
    wb_tag_o      = '0;
    tag_wr_en_o   = 1'b0;
    tag_wr_set_o  = '0;
    tag_wr_way_o  = '0;
    tag_wr_tag_o  = '0;
    done_o        = 1'b0;
    done_way_o    = '0;
    done_evict_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        alloc_ready_o = 1'b1;
        if (alloc_valid_i) begin
          set_d   = alloc_set_i;
          tag_d   = alloc_tag_i;
          state_d = S_RD;
        end
      end
      S_RD: begin
        tag_rd_en_o  = 1'b1;
        tag_rd_set_o = set_q;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        valid_d = tag_valid_i;
        dirty_d = tag_dirty_i;
        for (int k = 0; k < NUM_WAYS; k++) tags_d[k] = tag_tags_i[k*TAG_W +: TAG_W];
        state_d = S_PICK;
      end
      S_PICK: begin
        plru_set_o   = set_q;
        plru_valid_o = valid_q;
        way_d   = hit_any ? hit_way : plru_victim_i;
        evict_d = hit_any ? 1'b0 : valid_q[plru_victim_i];
        state_d = (evict_d && dirty_q[way_d]) ? S_WB : S_INST;
      end
      S_WB: begin
        plru_set_o   = set_q;
        plru_valid_o = valid_q;
        wb_valid_o   = 1'b1;
        wb_set_o     = set_q;
        wb_way_o     = way_q;
        wb_tag_o     = tags_q[way_q];
        if (wb_ready_i) state_d = S_INST;
      end
      S_INST: begin
        plru_set_o    = set_q;
        plru_valid_o  = valid_q;
        tag_wr_en_o   = 1'b1;
        tag_wr_set_o  = set_q;
        tag_wr_way_o  = way_q;
        tag_wr_tag_o  = tag_q;
        plru_access_o = 1'b1;
        plru_way_o    = way_q;
        done_o        = 1'b1;
        done_way_o    = way_q;
        done_evict_o  = evict_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      tag_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      way_q   <= '0;
      evict_q <= 1'b0;
      for (int k = 0; k < NUM_WAYS; k++) tags_q[k] <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      way_q   <= way_d;
      evict_q <= evict_d;
      for (int k = 0; k < NUM_WAYS; k++) tags_q[k] <= tags_d[k];
    end
  end

endmodule
